// File: rtl/ahb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ahb_pkg
// Description : Shared AHB-Lite encodings (HTRANS, HSIZE, HRESP) and the
//               slave data-phase state type.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   // IDLE: no data phase, DATA: legal data phase, ERR1/ERR2: two-cycle ERROR
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_ERR1 = 2'd2,
      ST_ERR2 = 2'd3
   } ahb_state_e;

endpackage
`default_nettype wire

// File: rtl/ahb_lane_mask.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ahb_lane_mask
// Description : Converts an AHB transfer size and byte offset into a
//               little-endian 4-bit byte-lane enable. Sizes above a word
//               produce an empty mask.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_lane_mask
   import ahb_pkg::*;
(
   input  logic [2:0] hsize,
   input  logic [1:0] offset,
   output logic [3:0] byte_en
);

   // Byte: single lane at the offset; half: low or high pair; word: all lanes
   always_comb begin
      byte_en = 4'b0000;
      case (hsize)
         HSIZE_BYTE: byte_en = 4'b0001 << offset;
         HSIZE_HALF: byte_en = offset[1] ? 4'b1100 : 4'b0011;
         HSIZE_WORD: byte_en = 4'b1111;
         default:    byte_en = 4'b0000;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/ahb_regbank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ahb_regbank
// Description : AHB-Lite slave register bank with NUM_REGS 32-bit registers,
//               read-only status slots, byte-lane writes, two-cycle ERROR
//               response and per-register write strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_regbank
   import ahb_pkg::*;
#(
   parameter int                  NUM_REGS = 8,
   parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
   parameter logic [31:0]         RST_VAL  = 32'h0000_0000
) (
   input  logic                     hclk,
   input  logic                     hresetn,
   input  logic                     hsel,
   input  logic [31:0]              haddr,
   input  logic [1:0]               htrans,
   input  logic                     hwrite,
   input  logic [2:0]               hsize,
   input  logic [2:0]               hburst,
   input  logic [31:0]              hwdata,
   input  logic                     hready_in,
   output logic                     hready,
   output logic [31:0]              hrdata,
   output logic [1:0]               hresp,
   output logic [NUM_REGS*32-1:0]   reg_out,
   input  logic [NUM_REGS*32-1:0]   sts_in,
   output logic [NUM_REGS-1:0]      wr_pulse
);

   localparam int AW = $clog2(NUM_REGS);

   ahb_state_e          state_q, state_d;
   logic [AW-1:0]       idx_q, idx_d;
   logic [1:0]          off_q, off_d;
   logic [2:0]          size_q, size_d;
   logic                write_q, write_d;
   logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

   logic          accept;
   logic          illegal;
   logic          commit;
   logic [AW-1:0] idx_a;
   logic [3:0]    byte_en;
   logic [31:0]   rd_word;
   logic          unused_bits;

   // Bursts are handled beat-by-beat and only the 4 KB window is decoded
   assign unused_bits = ^{hburst, haddr[31:12]};

   assign accept = hsel & hready_in & htrans[1];
   assign idx_a  = haddr[AW+1:2];
   assign commit = (state_q == ST_DATA) && write_q;

   // Classify the address phase: bad size, misalignment, hole in window, RO write
   always_comb begin
      illegal = 1'b0;
      if (hsize > HSIZE_WORD)                             illegal = 1'b1;
      if ((hsize == HSIZE_HALF) && haddr[0])              illegal = 1'b1;
      if ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00)) illegal = 1'b1;
      if (haddr[11:AW+2] != '0)                           illegal = 1'b1;
      if (hwrite && RO_MASK[idx_a])                       illegal = 1'b1;
   end

   // Next-state and address-phase capture; ERR1 never accepts (hready_in is low)
   always_comb begin
      state_d    = ST_IDLE;
      idx_d      = idx_q;
      off_d      = off_q;
      size_d     = size_q;
      write_d    = write_q;
      wr_pulse_d = '0;
      if (state_q == ST_ERR1) begin
         state_d = ST_ERR2;
      end else if (accept) begin
         state_d = illegal ? ST_ERR1 : ST_DATA;
         idx_d   = idx_a;
         off_d   = haddr[1:0];
         size_d  = hsize;
         write_d = hwrite;
      end
      for (int i = 0; i < NUM_REGS; i++) begin
         wr_pulse_d[i] = commit && (idx_q == i[AW-1:0]);
      end
   end

   // Control state register
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         off_q      <= 2'b00;
         size_q     <= 3'b000;
         write_q    <= 1'b0;
         wr_pulse_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         off_q      <= off_d;
         size_q     <= size_d;
         write_q    <= write_d;
         wr_pulse_q <= wr_pulse_d;
      end
   end

   ahb_lane_mask u_lane_mask (
      .hsize   (size_q),
      .offset  (off_q),
      .byte_en (byte_en)
   );

   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         if (RO_MASK[gi]) begin : g_ro
            assign reg_out[gi*32 +: 32] = 32'h0000_0000;
         end else begin : g_rw
            logic [31:0] reg_q, reg_d;

            // Merge the selected byte lanes of hwdata at the end of the data phase
            always_comb begin
               reg_d = reg_q;
               if (commit && (idx_q == gi[AW-1:0])) begin
                  for (int b = 0; b < 4; b++) begin
                     if (byte_en[b]) reg_d[8*b +: 8] = hwdata[8*b +: 8];
                  end
               end
            end

            // Register storage
            always_ff @(posedge hclk or negedge hresetn) begin
               if (!hresetn) reg_q <= RST_VAL;
               else          reg_q <= reg_d;
            end

            assign reg_out[gi*32 +: 32] = reg_q;
         end
      end
   endgenerate

   assign rd_word  = RO_MASK[idx_q] ? sts_in[{idx_q, 5'b00000} +: 32]
                                    : reg_out[{idx_q, 5'b00000} +: 32];
   assign hrdata   = ((state_q == ST_DATA) && !write_q) ? rd_word : 32'h0000_0000;
   assign hready   = (state_q != ST_ERR1);
   assign hresp    = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
   assign wr_pulse = wr_pulse_q;

endmodule
`default_nettype wire
